// File: rtl/snd_pdm_out.sv
// snd_pdm_out -- audio output stage for the board's RC-filtered audio pin.
// Holds each incoming sample, smooths it with a first-order IIR low-pass
// (coefficient 2^-FILT_SHIFT per ce pulse) and drives a first-order
// sigma-delta bitstream. A watchdog returns the output to mid-scale when the
// sample stream stops, and mute pulls the filter target to zero.
//
// Ports:
//   clk32         in   system clock, all state on rising edge
//   _reset        in   synchronous active-low reset
//   ce            in   filter clock enable
//   sample_in     in   11-bit signed sample, valid with sample_strobe
//   sample_strobe in   single-cycle capture pulse
//   mute          in   level-sensitive, forces filter target to 0
//   pdm_out       out  registered sigma-delta bitstream
//   level_out     out  registered filtered level (signed 11-bit)
//   active        out  1 while samples keep arriving within TIMEOUT
module snd_pdm_out #(
   parameter int FILT_SHIFT = 4,
   parameter int TIMEOUT    = 4096
) (
   input  logic               clk32,
   input  logic               _reset,
   input  logic               ce,
   input  logic signed [10:0] sample_in,
   input  logic               sample_strobe,
   input  logic               mute,
   output logic               pdm_out,
   output logic signed [10:0] level_out,
   output logic               active
);

   localparam int AW = 12 + FILT_SHIFT;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   logic signed [10:0]   hold;
   logic [TW-1:0]        tcnt;
   logic signed [AW-1:0] acc;
   logic [10:0]          sd_acc;

   logic signed [10:0]   target;
   logic signed [10:0]   y;
   logic signed [10:0]   y_next;
   logic signed [AW-1:0] acc_next;
   logic [10:0]          u;
   logic [11:0]          sum;

   always_comb begin
      target   = mute ? 11'sd0 : hold;
      // Arithmetic shift followed by truncation to 11 bits is just a bit slice.
      y        = acc[FILT_SHIFT +: 11];
      acc_next = acc + {{(AW-11){target[10]}}, target} - {{(AW-11){y[10]}}, y};
      y_next   = acc_next[FILT_SHIFT +: 11];
      // Offset-binary view of the level: 0 maps to mid-scale 1024.
      u        = {~level_out[10], level_out[9:0]};
      sum      = {1'b0, sd_acc} + {1'b0, u};
   end

   always_ff @(posedge clk32) begin
      if (!_reset) begin
         hold      <= '0;
         tcnt      <= '0;
         active    <= 1'b0;
         acc       <= '0;
         level_out <= '0;
         sd_acc    <= '0;
         pdm_out   <= 1'b0;
      end else begin
         // Capture beats the watchdog when both land on the same edge.
         if (sample_strobe) begin
            hold   <= sample_in;
            tcnt   <= '0;
            active <= 1'b1;
         end else if (tcnt != TMAX) begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == TLAST) begin
               hold   <= '0;
               active <= 1'b0;
            end
         end

         if (ce) begin
            acc       <= acc_next;
            level_out <= y_next;
         end

         // Carry out of the 11-bit accumulator is the output bit.
         sd_acc  <= sum[10:0];
         pdm_out <= sum[11];
      end
   end

endmodule

// File: tb/tb_snd_pdm_out.sv
// Bench for snd_pdm_out: a cycle model pushes expected outputs into a
// scoreboard queue as each cycle's stimulus is driven; the entry is popped and
// compared after the edge. Scenario checks (convergence, density, watchdog
// timing) compare against constants derived from the block's intent.
module tb_snd_pdm_out;
   localparam int FS = 4;
   localparam int TO = 4096;

   logic               clk32 = 1'b0;
   logic               rst_n;
   logic               ce;
   logic signed [10:0] sample_in;
   logic               sample_strobe;
   logic               mute;
   logic               pdm_out;
   logic signed [10:0] level_out;
   logic               active;

   snd_pdm_out #(.FILT_SHIFT(FS), .TIMEOUT(TO)) dut (
      .clk32         (clk32),
      ._reset        (rst_n),
      .ce            (ce),
      .sample_in     (sample_in),
      .sample_strobe (sample_strobe),
      .mute          (mute),
      .pdm_out       (pdm_out),
      .level_out     (level_out),
      .active        (active)
   );

   always #15 clk32 = ~clk32;

   typedef struct {int pdm; int lvl; int act;} exp_t;
   exp_t sb[$];

   int n_chk = 0;
   int n_fail = 0;

   // reference state
   int m_hold = 0, m_tcnt = 0, m_act = 0, m_acc = 0, m_lvl = 0, m_sd = 0, m_pdm = 0;

   int cyc_n = 0;
   int ce_per = 4;
   bit auto_en = 0;
   int auto_val = 0;
   bit s_strobe = 0;
   int s_val = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // floor(a / 2^FS)
   function automatic int fdiv(input int a);
      int d;
      d = 1 << FS;
      if (a >= 0) return a / d;
      return -((-a + d - 1) / d);
   endfunction

   task automatic cyc();
      int tgt, y, s;
      exp_t e;
      @(negedge clk32);
      ce            = ((cyc_n % ce_per) == 0);
      sample_strobe = s_strobe || (auto_en && (cyc_n % 1000) == 0);
      sample_in     = s_strobe ? 11'(s_val) : 11'(auto_val);
      s_strobe      = 0;
      if (!rst_n) begin
         m_hold = 0; m_tcnt = 0; m_act = 0; m_acc = 0; m_lvl = 0; m_sd = 0; m_pdm = 0;
      end else begin
         tgt = mute ? 0 : m_hold;
         s = m_sd + m_lvl + 1024;
         m_pdm = s / 2048;
         m_sd  = s % 2048;
         if (ce) begin
            y = fdiv(m_acc);
            m_acc = m_acc + tgt - y;
            m_lvl = fdiv(m_acc);
         end
         if (sample_strobe) begin
            m_hold = int'(sample_in); m_tcnt = 0; m_act = 1;
         end else if (m_tcnt < TO) begin
            m_tcnt++;
            if (m_tcnt == TO) begin m_hold = 0; m_act = 0; end
         end
      end
      e.pdm = m_pdm; e.lvl = m_lvl; e.act = m_act;
      sb.push_back(e);
      @(posedge clk32);
      #1;
      e = sb.pop_front();
      chk("pdm", int'(pdm_out), e.pdm);
      chk("level", int'(level_out), e.lvl);
      chk("active", int'(active), e.act);
      cyc_n++;
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   // Wait for level_out to reach tgt within max_ce pulses, checking monotonicity.
   task automatic wait_lvl(input string tag, input int tgt, input int max_ce);
      int pulses, prev, cur, lim;
      bit up, mono;
      pulses = 0; mono = 1;
      prev = int'(level_out);
      up = (tgt >= prev);
      lim = max_ce * ce_per + 8;
      for (int i = 0; i < lim && int'(level_out) != tgt; i++) begin
         cyc();
         if (ce) pulses++;
         cur = int'(level_out);
         if (up && cur < prev) mono = 0;
         if (!up && cur > prev) mono = 0;
         prev = cur;
      end
      chk({tag, "_conv"}, int'(level_out), tgt);
      chk({tag, "_ce_bound"}, int'(pulses <= max_ce), 1);
      chk({tag, "_mono"}, int'(mono), 1);
   endtask

   task automatic count_ones(input string tag, input int n, input int exp);
      int ones;
      ones = 0;
      for (int i = 0; i < n; i++) begin
         cyc();
         ones += int'(pdm_out);
      end
      chk({tag, "_ones"}, ones, exp);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1);
   end

   initial begin
      int act_cnt;
      rst_n = 0; ce = 0; sample_in = '0; sample_strobe = 0; mute = 0;

      // reset held with strobes and ce active
      ce_per = 1;
      for (int i = 0; i < 4; i++) begin
         s_strobe = 1; s_val = 300;
         cyc();
         chk("rst_pdm", int'(pdm_out), 0);
         chk("rst_level", int'(level_out), 0);
         chk("rst_active", int'(active), 0);
      end

      // release: mid-scale toggling, inactive
      rst_n = 1; ce_per = 4;
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("toggle", int'(pdm_out), i % 2);
         chk("idle_active", int'(active), 0);
      end

      // step to +512
      s_strobe = 1; s_val = 512; auto_en = 1; auto_val = 512;
      cyc();
      chk("capture_latency", int'(level_out), 0);
      chk("capture_active", int'(active), 1);
      wait_lvl("step512", 512, 400);
      count_ones("step512", 2048, 1536);

      // watchdog
      auto_en = 0;
      s_strobe = 1; s_val = -300;
      cyc();
      act_cnt = 0;
      for (int k = 1; k < TO; k++) begin
         cyc();
         act_cnt += int'(active);
      end
      chk("wd_active_cycles", act_cnt, TO - 1);
      chk("wd_pre_level", int'(level_out), -300);
      cyc();
      chk("wd_drop", int'(active), 0);
      wait_lvl("wd_decay", 0, 400);

      // strobe collides with the timeout edge
      s_strobe = 1; s_val = 200;
      cyc();
      run(TO - 1);
      s_strobe = 1; s_val = 100;
      cyc();
      chk("coll_active", int'(active), 1);
      cyc();
      chk("coll_active_hold", int'(active), 1);
      wait_lvl("coll", 100, 400);

      // full scale, mute, unmute
      auto_en = 1; auto_val = 1023;
      s_strobe = 1; s_val = 1023;
      cyc();
      wait_lvl("fs", 1023, 400);
      count_ones("fs", 2048, 2047);
      mute = 1;
      wait_lvl("mute", 0, 400);
      count_ones("mute", 2048, 1024);
      mute = 0;
      wait_lvl("unmute", 1023, 400);

      // negative extreme
      auto_val = -1024;
      s_strobe = 1; s_val = -1024;
      cyc();
      wait_lvl("neg", -1024, 400);
      count_ones("neg", 4096, 0);

      // one-cycle reset mid-stream
      rst_n = 0; s_strobe = 1; s_val = 400;
      cyc();
      chk("mrst_pdm", int'(pdm_out), 0);
      chk("mrst_level", int'(level_out), 0);
      chk("mrst_active", int'(active), 0);
      rst_n = 1; auto_en = 0;
      run(3);
      chk("mrst_idle", int'(active), 0);
      s_strobe = 1; s_val = 77;
      cyc();
      chk("mrst_resume", int'(active), 1);
      wait_lvl("resume", 77, 400);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
